// File: rtl/hp_manager_if.sv
// Game-logic side of the HP manager: play requests in, HP and status flags out.
interface hp_manager_if;
    logic       START;
    logic       DAMAGE;
    logic       HEAL;
    logic [3:0] OUT_HP;
    logic       DEAD;
    logic       INVULN;
    logic       HIT;

    modport master (output START, DAMAGE, HEAL, input OUT_HP, DEAD, INVULN, HIT);
    modport slave  (input START, DAMAGE, HEAL, output OUT_HP, DEAD, INVULN, HIT);
endinterface

// File: rtl/hp_manager.sv
// Saturating hit-point counter with post-hit invulnerability window and a
// restartable DEAD state; feeds the 4-bit HP value to the LED bar display.
module hp_manager #(
    parameter int MAX_HP        = 10,
    parameter int INIT_HP       = 10,
    parameter int DMG_STEP      = 1,
    parameter int HEAL_STEP     = 1,
    parameter int INVULN_CYCLES = 25000000
) (
    input  logic         CLK,
    input  logic         RST,
    hp_manager_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIVE,
        ST_INVULN,
        ST_DEAD
    } state_t;

    localparam logic [4:0]  MAX5       = 5'(MAX_HP);
    localparam logic [4:0]  DSTEP5     = 5'(DMG_STEP);
    localparam logic [4:0]  HSTEP5     = 5'(HEAL_STEP);
    localparam logic [3:0]  INIT4      = 4'(INIT_HP);
    localparam logic [24:0] TIMER_LOAD = 25'(INVULN_CYCLES - 1);

    // 5-bit intermediates keep the compare honest before the result is narrowed.
    function automatic logic [3:0] sat_sub(input logic [3:0] hp, input logic [4:0] step);
        logic [4:0] diff;
        diff = {1'b0, hp} - step;
        if ({1'b0, hp} <= step) return 4'd0;
        return diff[3:0];
    endfunction

    function automatic logic [3:0] sat_add(input logic [3:0] hp, input logic [4:0] step);
        logic [4:0] sum;
        sum = {1'b0, hp} + step;
        if (sum > MAX5) return MAX5[3:0];
        return sum[3:0];
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  hp_q, hp_d;
    logic [24:0] timer_q, timer_d;
    logic        hit_q, hit_d;
    logic        dead_q, invuln_q;
    logic        dmg_prev_q, heal_prev_q;
    logic        dmg_edge, heal_edge;
    logic [3:0]  hp_after_dmg, hp_after_heal;

    assign dmg_edge      = bus.DAMAGE & ~dmg_prev_q;
    assign heal_edge     = bus.HEAL & ~heal_prev_q;
    assign hp_after_dmg  = sat_sub(hp_q, DSTEP5);
    assign hp_after_heal = sat_add(hp_q, HSTEP5);

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        timer_d = timer_q;
        hit_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_ALIVE;
                    hp_d    = INIT4;
                end
            end
            ST_ALIVE: begin
                // Damage wins over a coincident heal.
                if (dmg_edge) begin
                    hp_d  = hp_after_dmg;
                    hit_d = 1'b1;
                    if (hp_after_dmg == 4'd0) begin
                        state_d = ST_DEAD;
                    end else begin
                        state_d = ST_INVULN;
                        timer_d = TIMER_LOAD;
                    end
                end else if (heal_edge) begin
                    hp_d = hp_after_heal;
                end
            end
            ST_INVULN: begin
                if (heal_edge) hp_d = hp_after_heal;
                if (timer_q == 25'd0) state_d = ST_ALIVE;
                else                  timer_d = timer_q - 25'd1;
            end
            ST_DEAD: begin
                hp_d = 4'd0;
                if (bus.START) begin
                    state_d = ST_ALIVE;
                    hp_d    = INIT4;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with HP/HIT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            hp_q        <= 4'd0;
            timer_q     <= 25'd0;
            hit_q       <= 1'b0;
            dead_q      <= 1'b0;
            invuln_q    <= 1'b0;
            dmg_prev_q  <= 1'b0;
            heal_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            timer_q     <= timer_d;
            hit_q       <= hit_d;
            dead_q      <= (state_d == ST_DEAD);
            invuln_q    <= (state_d == ST_INVULN);
            dmg_prev_q  <= bus.DAMAGE;
            heal_prev_q <= bus.HEAL;
        end
    end

    assign bus.OUT_HP = hp_q;
    assign bus.DEAD   = dead_q;
    assign bus.INVULN = invuln_q;
    assign bus.HIT    = hit_q;

endmodule

// File: tb/tb_hp_manager.sv
// Bench for hp_manager: two parameterisations driven by the same stimulus,
// each compared every cycle against an event-level HP model.
module tb_hp_manager;

    logic clk;
    logic rst_n;
    logic start, dmg, heal;

    int n_tests;
    int n_fail;

    hp_manager_if bus_a ();
    hp_manager_if bus_b ();

    assign bus_a.START  = start;
    assign bus_a.DAMAGE = dmg;
    assign bus_a.HEAL   = heal;
    assign bus_b.START  = start;
    assign bus_b.DAMAGE = dmg;
    assign bus_b.HEAL   = heal;

    hp_manager #(.MAX_HP(10), .INIT_HP(10), .DMG_STEP(1), .HEAL_STEP(1), .INVULN_CYCLES(4))
        dut_a (.CLK(clk), .RST(rst_n), .bus(bus_a));

    hp_manager #(.MAX_HP(12), .INIT_HP(10), .DMG_STEP(3), .HEAL_STEP(2), .INVULN_CYCLES(3))
        dut_b (.CLK(clk), .RST(rst_n), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        int max_hp;
        int init_hp;
        int dstep;
        int hstep;
        int inv;
        bit playing;
        bit dead;
        int hp;
        int inv_left;
        bit hit;
        bit pd;
        bit ph;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset(input mdl_t m);
        mdl_t r;
        r          = m;
        r.playing  = 1'b0;
        r.dead     = 1'b0;
        r.hp       = 0;
        r.inv_left = 0;
        r.hit      = 1'b0;
        r.pd       = 1'b0;
        r.ph       = 1'b0;
        return r;
    endfunction

    // One clock of game rules: events are rising edges, damage beats heal,
    // damage is ignored while the invulnerability countdown is running.
    function automatic mdl_t mdl_step(input mdl_t m, input bit s, input bit d, input bit h);
        mdl_t r;
        bit de, he;
        r     = m;
        de    = d && !m.pd;
        he    = h && !m.ph;
        r.pd  = d;
        r.ph  = h;
        r.hit = 1'b0;
        if (!m.playing) begin
            if (s) begin
                r.playing = 1'b1;
                r.dead    = 1'b0;
                r.hp      = m.init_hp;
            end
        end else if (m.inv_left > 0) begin
            r.inv_left = m.inv_left - 1;
            if (he) r.hp = (m.hp + m.hstep > m.max_hp) ? m.max_hp : m.hp + m.hstep;
        end else if (de) begin
            r.hit = 1'b1;
            r.hp  = (m.hp - m.dstep < 0) ? 0 : m.hp - m.dstep;
            if (r.hp == 0) begin
                r.playing = 1'b0;
                r.dead    = 1'b1;
            end else begin
                r.inv_left = m.inv;
            end
        end else if (he) begin
            r.hp = (m.hp + m.hstep > m.max_hp) ? m.max_hp : m.hp + m.hstep;
        end
        return r;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_dut(input string nm, input mdl_t m, input logic [3:0] hp,
                               input logic dead, input logic inv, input logic hit);
        check({nm, ".hp"},     int'(hp),   m.hp);
        check({nm, ".dead"},   int'(dead), int'(m.dead));
        check({nm, ".invuln"}, int'(inv),  int'(m.inv_left > 0));
        check({nm, ".hit"},    int'(hit),  int'(m.hit));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            ma = mdl_reset(ma);
            mb = mdl_reset(mb);
        end else begin
            ma = mdl_step(ma, start, dmg, heal);
            mb = mdl_step(mb, start, dmg, heal);
        end
        #1;
        compare_dut("a", ma, bus_a.OUT_HP, bus_a.DEAD, bus_a.INVULN, bus_a.HIT);
        compare_dut("b", mb, bus_b.OUT_HP, bus_b.DEAD, bus_b.INVULN, bus_b.HIT);
    endtask

    task automatic apply(input bit s, input bit d, input bit h, input int n);
        start = s;
        dmg   = d;
        heal  = h;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Reset is pulled between clock edges; outputs must clear before any edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.a_hp",  int'(bus_a.OUT_HP), 0);
        check("arst.a_inv", int'(bus_a.INVULN), 0);
        check("arst.a_hit", int'(bus_a.HIT),    0);
        check("arst.b_hp",  int'(bus_b.OUT_HP), 0);
        check("arst.b_dead", int'(bus_b.DEAD),  0);
        ma = mdl_reset(ma);
        mb = mdl_reset(mb);
        cycle();
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 2);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        dmg     = 1'b0;
        heal    = 1'b0;
        ma = '0;
        ma.max_hp = 10; ma.init_hp = 10; ma.dstep = 1; ma.hstep = 1; ma.inv = 4;
        mb = '0;
        mb.max_hp = 12; mb.init_hp = 10; mb.dstep = 3; mb.hstep = 2; mb.inv = 3;
        ma = mdl_reset(ma);
        mb = mdl_reset(mb);

        #2;
        check("rst.hp",     int'(bus_a.OUT_HP), 0);
        check("rst.dead",   int'(bus_a.DEAD),   0);
        check("rst.invuln", int'(bus_a.INVULN), 0);
        check("rst.hit",    int'(bus_a.HIT),    0);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Edges in IDLE are ignored.
        apply(0, 1, 1, 2);
        apply(0, 0, 0, 1);
        apply(1, 0, 0, 1);
        check("start.hp", int'(bus_a.OUT_HP), 10);
        apply(0, 0, 0, 1);

        // Held damage: one hit, then a window.
        apply(0, 1, 0, 10);
        check("hold.hp", int'(bus_a.OUT_HP), 9);
        apply(0, 0, 0, 1);
        apply(0, 1, 0, 1);
        apply(0, 0, 0, 1);
        apply(0, 1, 0, 1);
        apply(0, 0, 0, 3);
        apply(0, 1, 0, 1);
        apply(0, 0, 0, 5);

        // Heal saturation and simultaneous damage+heal.
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 1);
            apply(0, 0, 0, 1);
        end
        apply(0, 1, 1, 1);
        apply(0, 0, 0, 6);

        // Drive dut_b to death, try heal, restart.
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 1);
            apply(0, 0, 0, 5);
        end
        check("death.b_dead", int'(bus_b.DEAD), 1);
        apply(0, 0, 1, 1);
        apply(0, 0, 0, 1);
        apply(1, 0, 0, 1);
        apply(0, 0, 0, 1);

        // Async reset mid-invulnerability.
        apply(0, 1, 0, 1);
        async_reset();
        apply(1, 0, 0, 1);
        apply(0, 0, 0, 1);

        // Random play.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            dmg   = ($urandom_range(0, 1) == 1);
            heal  = ($urandom_range(0, 5) == 0);
            if (i % 600 == 599) async_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hp_manager.md
# hp_manager

Hit-point bookkeeping block that produces the 4-bit HP value consumed by the LED bar-graph display. It turns damage and heal requests from game logic into a saturating HP count. A post-hit invulnerability window absorbs repeated damage. A DEAD flag is raised when HP reaches zero, and the block can be restarted from DEAD.

## Interface
Parameters:
- MAX_HP, 10: HP ceiling; legal range 1..15; 10 matches the 10-LED display.
- INIT_HP, 10: HP loaded on start/restart; legal range 1..MAX_HP.
- DMG_STEP, 1: HP removed per accepted damage event; legal range 1..15.
- HEAL_STEP, 1: HP added per accepted heal event; legal range 1..15.
- INVULN_CYCLES, 25000000: invulnerability length in CLK cycles (0.5 s at 50 MHz); legal range 1..2^25-1.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  level; starts play from IDLE or DEAD.
- DAMAGE  input  1  level, synchronous to CLK; each rising edge is one damage request.
- HEAL  input  1  level, synchronous to CLK; each rising edge is one heal request.
- OUT_HP  output  4  current HP, 0..MAX_HP; drives the display's IN_HP.
- DEAD  output  1  high while in DEAD.
- INVULN  output  1  high while in INVULN.
- HIT  output  1  one-cycle pulse when a damage request is applied.

## Operation
- Edge detection: DAMAGE and HEAL are each registered. A rising edge is current=1 with previous=0. Holding an input high yields exactly one event.
- States: IDLE, ALIVE, INVULN, DEAD. All outputs are registered.
- Reset (RST low, async): state=IDLE, OUT_HP=0, DEAD=0, INVULN=0, HIT=0, edge registers=0, timer=0.
- IDLE:
  - START=1 -> ALIVE, OUT_HP<=INIT_HP.
  - DAMAGE/HEAL edges are ignored.
- ALIVE:
  - Damage edge: OUT_HP<=max(OUT_HP-DMG_STEP,0) and HIT=1 for one cycle.
    - Result 0 -> DEAD.
    - Otherwise -> INVULN, with timer loaded to INVULN_CYCLES-1.
  - Heal edge (no damage edge): OUT_HP<=min(OUT_HP+HEAL_STEP,MAX_HP). State is unchanged.
  - Damage and heal edges in the same cycle: damage is applied, heal is discarded.
- INVULN:
  - Damage edges are ignored: no HIT, no HP change.
  - Heal edges apply exactly as in ALIVE.
  - Timer decrements every cycle. In the cycle where timer==0, the next state is ALIVE.
  - INVULN output is high for exactly INVULN_CYCLES cycles.
- DEAD:
  - OUT_HP=0, DEAD=1; heal and damage edges are ignored.
  - START=1 -> ALIVE, OUT_HP<=INIT_HP, DEAD<=0.
- Arithmetic:
  - Use 5-bit intermediates so subtraction cannot wrap below 0 and addition cannot overflow past 15 before clamping.
  - OUT_HP never exceeds MAX_HP and never reads 10..15 unless MAX_HP permits it.
- START while in ALIVE or INVULN has no effect.

## Timing
- Event latency: input high at posedge n with low at posedge n-1 -> OUT_HP/HIT/state update visible after posedge n, i.e. in cycle n+1. HIT deasserts after posedge n+1.
- START latency: one cycle, START sampled at posedge n -> OUT_HP=INIT_HP in cycle n+1.
- INVULN asserts in the same cycle as HIT. It deasserts INVULN_CYCLES cycles later. A damage edge in the first ALIVE cycle after that is accepted.
- Edge registers update in every state, including IDLE/DEAD. A DAMAGE held high across the INVULN->ALIVE boundary therefore produces no new event.
- RST assertion mid-INVULN or mid-HIT clears all outputs immediately (async), without waiting for a clock edge. Release returns to IDLE.
- Inputs are assumed already synchronized/debounced upstream; no metastability handling is required here.

## Test plan
- Reset/start: RST low -> OUT_HP=0, DEAD=0, INVULN=0, HIT=0. Release, START pulse -> OUT_HP=10 next cycle.
- Single hit (INVULN_CYCLES=4): DAMAGE 0->1 held 10 cycles -> OUT_HP 10->9 once, HIT one cycle, INVULN high exactly 4 cycles.
- Invulnerability: second DAMAGE edge 2 cycles after the first -> OUT_HP stays 9, no HIT. An edge 1 cycle after INVULN falls -> OUT_HP=8.
- Heal saturation: at HP=9, two HEAL edges -> 10 then 10. DAMAGE and HEAL edges in the same cycle at HP=10 -> 9, HIT=1.
- Death/restart (DMG_STEP=3, INIT_HP=10): four spaced hits -> 7, 4, 1, 0. DEAD=1 on the fourth. A HEAL edge then changes nothing. START -> OUT_HP=10, DEAD=0.
- Async reset mid-INVULN: RST low between clock edges -> outputs clear immediately. After release -> IDLE, OUT_HP=0 until START.
